// File: rtl/belt_driver_pkg.sv
// Opcode values, FSM state encoding and strobe selection for the data-belt initiator.
package belt_driver_pkg;

  localparam int BELT_OP_W = 3;

  localparam logic [BELT_OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [BELT_OP_W-1:0] OP_INC  = 3'd1;
  localparam logic [BELT_OP_W-1:0] OP_DEC  = 3'd2;
  localparam logic [BELT_OP_W-1:0] OP_FWD  = 3'd3;
  localparam logic [BELT_OP_W-1:0] OP_BACK = 3'd4;
  localparam logic [BELT_OP_W-1:0] OP_IN   = 3'd5;
  localparam logic [BELT_OP_W-1:0] OP_OUT  = 3'd6;
  localparam logic [BELT_OP_W-1:0] OP_NOP7 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREP     = 3'd1,
    ST_STROBE   = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WAIT_OUT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    STB_WR  = 2'd0,
    STB_SHL = 2'd1,
    STB_SHR = 2'd2
  } strobe_t;

endpackage

// File: rtl/belt_driver.sv
// Data-belt initiator: turns BF data ops into clean single-cycle belt strobes with
// setup (PREP) and recovery (RECOVER) cycles, plus byte in/out handshakes.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | ready for an op; NOP completes here in one cycle
// ST_PREP     | belt_di settled, raise the selected strobe
// ST_STROBE   | strobe high for exactly this cycle
// ST_RECOVER  | strobes low, belt_do settles before the next op
// ST_WAIT_IN  | waiting for an input byte to write into the cell
// ST_WAIT_OUT | output byte pending until the consumer takes it
module belt_driver
  import belt_driver_pkg::*;
#(
  parameter int BITSIZE = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 op_valid,
  input  logic [BELT_OP_W-1:0] op_code,
  output logic                 op_ready,
  output logic                 zero,
  input  logic                 in_valid,
  input  logic [BITSIZE-1:0]   in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BITSIZE-1:0]   out_data,
  input  logic                 out_ready,
  output logic                 belt_shl,
  output logic                 belt_shr,
  output logic                 belt_wr,
  output logic [BITSIZE-1:0]   belt_di,
  input  logic [BITSIZE-1:0]   belt_do
);

  localparam logic [BITSIZE-1:0] ONE = {{(BITSIZE-1){1'b0}}, 1'b1};

  state_t             state, state_n;
  strobe_t            stb_sel, stb_sel_n;
  logic               shl_n, shr_n, wr_n;
  logic               out_valid_n;
  logic [BITSIZE-1:0] belt_di_n, out_data_n;

  assign op_ready = (state == ST_IDLE) && rstn;
  assign in_ready = (state == ST_WAIT_IN) && rstn;
  assign zero     = (belt_do == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      stb_sel   <= STB_WR;
      belt_shl  <= 1'b0;
      belt_shr  <= 1'b0;
      belt_wr   <= 1'b0;
      belt_di   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      stb_sel   <= stb_sel_n;
      belt_shl  <= shl_n;
      belt_shr  <= shr_n;
      belt_wr   <= wr_n;
      belt_di   <= belt_di_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  // Strobes default low every cycle, so a pulse can only last the one cycle PREP sets it for.
  always_comb begin
    state_n     = state;
    stb_sel_n   = stb_sel;
    shl_n       = 1'b0;
    shr_n       = 1'b0;
    wr_n        = 1'b0;
    belt_di_n   = belt_di;
    out_valid_n = out_valid;
    out_data_n  = out_data;

    unique case (state)
      ST_IDLE: begin
        if (op_valid) begin
          unique case (op_code)
            OP_INC: begin
              belt_di_n = belt_do + ONE;
              stb_sel_n = STB_WR;
              state_n   = ST_PREP;
            end
            OP_DEC: begin
              belt_di_n = belt_do - ONE;
              stb_sel_n = STB_WR;
              state_n   = ST_PREP;
            end
            OP_FWD: begin
              stb_sel_n = STB_SHL;
              state_n   = ST_PREP;
            end
            OP_BACK: begin
              stb_sel_n = STB_SHR;
              state_n   = ST_PREP;
            end
            OP_IN: begin
              stb_sel_n = STB_WR;
              state_n   = ST_WAIT_IN;
            end
            OP_OUT: begin
              out_data_n  = belt_do;
              out_valid_n = 1'b1;
              state_n     = ST_WAIT_OUT;
            end
            OP_NOP, OP_NOP7: state_n = ST_IDLE;
            default:         state_n = ST_IDLE;
          endcase
        end
      end

      ST_PREP: begin
        unique case (stb_sel)
          STB_SHL: shl_n = 1'b1;
          STB_SHR: shr_n = 1'b1;
          default: wr_n  = 1'b1;
        endcase
        state_n = ST_STROBE;
      end

      ST_STROBE:  state_n = ST_RECOVER;

      ST_RECOVER: state_n = ST_IDLE;

      ST_WAIT_IN: begin
        if (in_valid) begin
          belt_di_n = in_data;
          stb_sel_n = STB_WR;
          state_n   = ST_PREP;
        end
      end

      ST_WAIT_OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_belt_driver.sv
// Bench for belt_driver: emulated belt memory, cycle-count model of expected outputs,
// per-cycle compare process plus directed literal checks.
module tb_belt_driver;
  localparam int BITSIZE = 8;
  localparam logic [2:0] C_NOP = 3'd0, C_INC = 3'd1, C_DEC = 3'd2, C_FWD = 3'd3,
                         C_BACK = 3'd4, C_IN = 3'd5, C_OUT = 3'd6, C_NOP7 = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, op_valid, op_ready, zero, in_valid, in_ready;
  logic [2:0]   op_code;
  logic [7:0]   in_data, out_data, belt_di, belt_do;
  logic         out_valid, out_ready, belt_shl, belt_shr, belt_wr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  belt_driver #(.BITSIZE(BITSIZE)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .zero(zero), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .belt_shl(belt_shl), .belt_shr(belt_shr), .belt_wr(belt_wr),
    .belt_di(belt_di), .belt_do(belt_do)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge-sensitive belt: acts on the first cycle a strobe is seen high.
  logic [7:0] mem [0:15];
  logic [3:0] ptr;
  logic       shl_q, shr_q, wr_q, pre_en;
  logic [7:0] pre_val;
  int         wr_n, shl_n, shr_n, act_xfers;
  assign belt_do = mem[ptr];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    ptr <= 4'd0; shl_q <= 1'b0; shr_q <= 1'b0; wr_q <= 1'b0;
    wr_n <= 0; shl_n <= 0; shr_n <= 0; act_xfers <= 0;
  end

  always @(posedge clk) begin
    shl_q <= belt_shl; shr_q <= belt_shr; wr_q <= belt_wr;
    if (pre_en) mem[ptr] <= pre_val;
    else if (belt_wr === 1'b1 && wr_q === 1'b0) begin
      mem[ptr] <= belt_di; wr_n <= wr_n + 1;
    end
    if (belt_shl === 1'b1 && shl_q === 1'b0) begin ptr <= ptr + 4'd1; shl_n <= shl_n + 1; end
    if (belt_shr === 1'b1 && shr_q === 1'b0) begin ptr <= ptr - 4'd1; shr_n <= shr_n + 1; end
    if (out_valid === 1'b1 && out_ready === 1'b1) act_xfers <= act_xfers + 1;
  end

  // Model: a strobe op occupies 3 cycles after acceptance, the pulse sits in the middle one.
  int         m_left = 0, m_kind = 0, low_run = 100;
  bit         m_win = 0, m_wout = 0, e_ov = 0, started = 0;
  logic [7:0] e_di = 8'h00, e_od = 8'h00;

  always @(posedge clk) begin
    started = 1;
    cyc++;
    if (!rstn) begin
      m_left = 0; m_win = 0; m_wout = 0; e_di = 8'h00; e_od = 8'h00; e_ov = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_win) begin
      if (in_valid) begin e_di = in_data; m_win = 0; m_left = 3; m_kind = 0; end
    end else if (m_wout) begin
      if (out_ready) begin e_ov = 0; m_wout = 0; end
    end else if (op_valid) begin
      case (op_code)
        C_INC:  begin e_di = belt_do + 8'd1; m_left = 3; m_kind = 0; end
        C_DEC:  begin e_di = belt_do - 8'd1; m_left = 3; m_kind = 0; end
        C_FWD:  begin m_left = 3; m_kind = 1; end
        C_BACK: begin m_left = 3; m_kind = 2; end
        C_IN:   m_win = 1;
        C_OUT:  begin e_od = belt_do; e_ov = 1; m_wout = 1; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk1("op_ready", op_ready, rstn && m_left == 0 && !m_win && !m_wout);
      chk1("in_ready", in_ready, rstn && m_win);
      chk1("belt_wr", belt_wr, m_left == 2 && m_kind == 0);
      chk1("belt_shl", belt_shl, m_left == 2 && m_kind == 1);
      chk1("belt_shr", belt_shr, m_left == 2 && m_kind == 2);
      chk8("belt_di", belt_di, e_di);
      chk1("out_valid", out_valid, e_ov);
      chk8("out_data", out_data, e_od);
      if (op_ready === 1'b1) chk1("zero", zero, belt_do == 8'h00);
      if (belt_shl || belt_shr || belt_wr) begin
        chk1("strobe_onehot", (belt_shl && belt_shr) || (belt_shl && belt_wr) || (belt_shr && belt_wr), 1'b0);
        chk1("strobe_gap", low_run >= 2, 1'b1);
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code);
    bit acc = 0;
    op_valid = 1'b1;
    op_code  = code;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = op_ready;
      tick();
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: op %0d not accepted within 20 cycles", code);
    end
  endtask

  task automatic wait_ready();
    bit rdy = 0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      rdy = op_ready;
      if (!rdy) tick();
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL ready_timeout: op_ready not back within 20 cycles");
    end
  endtask

  task automatic preload(input logic [7:0] v);
    pre_val = v; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; op_valid = 1'b0; op_code = C_NOP; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; pre_en = 1'b0; pre_val = 8'h00;

    // reset
    tick(); tick();
    chk1("rst_op_ready", op_ready, 1'b0);
    chk1("rst_wr", belt_wr, 1'b0);
    chk1("rst_shl", belt_shl, 1'b0);
    chk1("rst_shr", belt_shr, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_belt_di", belt_di, 8'h00);
    rstn = 1'b1;
    tick();
    chk1("post_rst_op_ready", op_ready, 1'b1);

    // INC wrapping FF -> 00
    preload(8'hFF);
    issue(C_INC); op_valid = 1'b0;
    chk8("inc_di_setup", belt_di, 8'h00);
    chk1("inc_wr_setup", belt_wr, 1'b0);
    tick();
    chk1("inc_wr_high", belt_wr, 1'b1);
    tick();
    chk1("inc_wr_low", belt_wr, 1'b0);
    chk1("inc_busy", op_ready, 1'b0);
    tick();
    chk1("inc_ready_k3", op_ready, 1'b1);
    chk8("inc_cell", belt_do, 8'h00);
    chk1("inc_zero", zero, 1'b1);

    // DEC wrapping 00 -> FF
    issue(C_DEC); op_valid = 1'b0;
    chk8("dec_di", belt_di, 8'hFF);
    wait_ready();
    chk8("dec_cell", belt_do, 8'hFF);
    chk1("dec_zero", zero, 1'b0);
    chkn("dec_wr_count", wr_n, 2);

    // FWD/BACK back-to-back, then touch a neighbouring cell
    issue(C_FWD);
    issue(C_BACK);
    op_valid = 1'b0;
    wait_ready();
    chkn("shl_count", shl_n, 1);
    chkn("shr_count", shr_n, 1);
    chk8("ptr_home", {4'h0, ptr}, 8'h00);
    issue(C_FWD);
    issue(C_INC);
    op_valid = 1'b0;
    wait_ready();
    chk8("cell1_inc", belt_do, 8'h01);
    issue(C_BACK); op_valid = 1'b0;
    wait_ready();
    chk8("cell0_back", belt_do, 8'hFF);

    // NOPs complete in one cycle each
    op_valid = 1'b1; op_code = C_NOP;
    tick();
    chk1("nop0_ready", op_ready, 1'b1);
    op_code = C_NOP7;
    tick();
    chk1("nop7_ready", op_ready, 1'b1);
    op_valid = 1'b0;

    // IN with a 5-cycle wait
    issue(C_IN); op_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("in_ready_wait", in_ready, 1'b1);
      if (i == 4) begin in_valid = 1'b1; in_data = 8'h41; end
      tick();
    end
    in_valid = 1'b0; in_data = 8'h00;
    chk1("in_ready_done", in_ready, 1'b0);
    chk8("in_di", belt_di, 8'h41);
    tick();
    chk1("in_wr_high", belt_wr, 1'b1);
    tick(); tick();
    chk1("in_ready_back", op_ready, 1'b1);
    chk8("in_cell", belt_do, 8'h41);

    // OUT held 4 cycles, then taken
    preload(8'h2A);
    issue(C_OUT); op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("out_hold_valid", out_valid, 1'b1);
      chk8("out_hold_data", out_data, 8'h2A);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("out_taken", out_valid, 1'b0);
    chk8("out_frozen", out_data, 8'h2A);
    chk1("out_ready_back", op_ready, 1'b1);
    chkn("out_xfers", act_xfers, 1);

    // OUT abandoned by reset
    preload(8'h55);
    issue(C_OUT); op_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk8("abort_out_data", out_data, 8'h00);
    tick();
    chk1("abort_ready", op_ready, 1'b1);
    chkn("abort_xfers", act_xfers, 1);

    // reset during a WR pulse: the write taken on the rising edge stands
    issue(C_INC); op_valid = 1'b0;
    tick();
    chk1("midrst_wr_high", belt_wr, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk1("midrst_wr_low", belt_wr, 1'b0);
    tick(); tick(); tick();
    chkn("midrst_wr_count", wr_n, 5);
    chk8("midrst_cell", belt_do, 8'h56);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
